// File: rtl/dht_pkg.sv
// Shared constants for the DHT22 polling block: FSM encoding, raw frame
// field positions and the humidity plausibility limit.
package dht_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_TRIG  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  // Raw 40-bit frame layout: [39:24] humidity, [23:8] temperature, [7:0] checksum
  localparam int FRAME_W   = 40;
  localparam int HUM_MSB   = 39;
  localparam int HUM_LSB   = 24;
  localparam int TEMP_SIGN = 23;
  localparam int TEMP_MSB  = 22;
  localparam int TEMP_LSB  = 8;
  localparam int SUM_LSB   = 0;

  // Byte lanes covered by the checksum
  localparam int BYTE4_LSB = 32;
  localparam int BYTE3_LSB = 24;
  localparam int BYTE2_LSB = 16;
  localparam int BYTE1_LSB = 8;

  // Largest plausible humidity reading (100.0 %RH)
  localparam logic [15:0] HUM_MAX = 16'd1000;

  typedef logic [FRAME_W-1:0] dht_frame_t;

endpackage

// File: rtl/dht_frame_check.sv
// Combinational validation and unit conversion of one raw DHT22 frame.
// Temperature arrives sign-magnitude and leaves as two's complement.
module dht_frame_check
  import dht_pkg::*;
(
  input  dht_frame_t  frame,
  output logic        ok,
  output logic [15:0] humidity,
  output logic [15:0] temperature
);

  logic [7:0]  sum;
  logic [14:0] temp_mag;

  // 8-bit sum wraps naturally, discarding carries
  assign sum = frame[BYTE4_LSB +: 8] + frame[BYTE3_LSB +: 8]
             + frame[BYTE2_LSB +: 8] + frame[BYTE1_LSB +: 8];

  assign humidity = frame[HUM_MSB:HUM_LSB];
  assign temp_mag = frame[TEMP_MSB:TEMP_LSB];

  // Sign-magnitude to two's complement
  assign temperature = frame[TEMP_SIGN] ? (16'd0 - {1'b0, temp_mag})
                                        : {1'b0, temp_mag};

  // An all-zero frame passes the checksum but means the reader returned nothing
  assign ok = (sum == frame[SUM_LSB +: 8])
           && (frame != '0)
           && (humidity <= HUM_MAX);

endmodule

// File: rtl/dht_poller.sv
// Periodic DHT22 poller: pulses the reader's active-low get input every
// POLL_CYCLES clocks, samples the returned frame SAMPLE_DELAY clocks later,
// and publishes the last good humidity/temperature with error tracking.
module dht_poller
  import dht_pkg::*;
#(
  parameter int POLL_CYCLES  = 2000000,
  parameter int SAMPLE_DELAY = 20000,
  parameter int GET_PULSE    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        dht_get,
  input  logic [39:0] dht_data,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        valid,
  output logic        new_sample,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int CW = $clog2(POLL_CYCLES);
  localparam logic [CW-1:0] LAST_GET    = CW'(GET_PULSE - 1);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(SAMPLE_DELAY - 1);
  localparam logic [CW-1:0] LAST_POLL   = CW'(POLL_CYCLES - 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          en_q;
  dht_frame_t    frame_q;
  logic          chk_ok;
  logic [15:0]   chk_hum;
  logic [15:0]   chk_temp;

  dht_frame_check u_check (
    .frame       (frame_q),
    .ok          (chk_ok),
    .humidity    (chk_hum),
    .temperature (chk_temp)
  );

  // Register enable once so decisions never see it change mid-cycle
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) en_q <= 1'b0;
    else        en_q <= enable;
  end

  // Next-state decode; enable is only consulted at the poll boundaries,
  // so a started trigger/sample cycle always runs to completion
  always_comb begin
    // NOTE: default first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en_q)              state_nxt = ST_TRIG;
      ST_TRIG:  if (cnt == LAST_GET)    state_nxt = ST_WAIT;
      ST_WAIT:  if (cnt == LAST_SAMPLE) state_nxt = ST_CHECK;
      ST_CHECK:                         state_nxt = ST_HOLD;
      ST_HOLD:  if (cnt == LAST_POLL)   state_nxt = en_q ? ST_TRIG : ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Poll counter: zero while idle and on the first trigger cycle of each poll
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                              cnt <= '0;
    else if (state == ST_IDLE || (state == ST_HOLD && cnt == LAST_POLL)) cnt <= '0;
    else                                                     cnt <= cnt + 1'b1;
  end

  // Registered trigger output; reset forces it high immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) dht_get <= 1'b1;
    else        dht_get <= (state_nxt != ST_TRIG);
  end

  // Capture the reader's frame on the way into CHECK
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          frame_q <= '0;
    else if (state == ST_WAIT && state_nxt == ST_CHECK)  frame_q <= dht_data;
  end

  // Publish the checked frame at the end of CHECK
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      humidity    <= '0;
      temperature <= '0;
      valid       <= 1'b0;
      new_sample  <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      new_sample <= 1'b0;
      if (state == ST_CHECK) begin
        if (chk_ok) begin
          humidity    <= chk_hum;
          temperature <= chk_temp;
          valid       <= 1'b1;
          new_sample  <= 1'b1;
          frame_err   <= 1'b0;
        end else begin
          frame_err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dht_poller.sv
// Bench for dht_poller: behavioural model of poll timing and frame rules,
// per-cycle output comparison, plus literal checks on key scenarios.
module tb_dht_poller;

  localparam int POLL   = 200;
  localparam int SAMPLE = 50;
  localparam int GET    = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        dht_get;
  logic [39:0] dht_data = 40'h028C010998;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        valid;
  logic        new_sample;
  logic        frame_err;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_err = 0;
  int ns_seen = 0;

  // Model expectations (reset values)
  logic        exp_get = 1'b1;
  logic [15:0] exp_hum = '0;
  logic [15:0] exp_temp = '0;
  logic        exp_valid = 1'b0;
  logic        exp_ns = 1'b0;
  logic        exp_ferr = 1'b0;
  logic [7:0]  exp_cnt = '0;

  dht_poller #(.POLL_CYCLES(POLL), .SAMPLE_DELAY(SAMPLE), .GET_PULSE(GET)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .dht_get     (dht_get),
    .dht_data    (dht_data),
    .humidity    (humidity),
    .temperature (temperature),
    .valid       (valid),
    .new_sample  (new_sample),
    .frame_err   (frame_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame acceptance rule from the sensor's data sheet view
  function automatic bit frame_good(input logic [39:0] f);
    int s;
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return ((s % 256) == int'(f[7:0])) && (f != 40'd0) && (f[39:24] <= 16'd1000);
  endfunction

  function automatic logic [15:0] frame_temp(input logic [39:0] f);
    int mag;
    int v;
    mag = int'(f[22:8]);
    v = f[23] ? -mag : mag;
    return v[15:0];
  endfunction

  // Build a frame from readings; bad_sum corrupts the checksum
  function automatic logic [39:0] make_frame(input logic [15:0] hum, input logic [14:0] mag,
                                             input logic neg, input bit bad_sum);
    logic [39:0] f;
    logic [7:0]  s;
    f = {hum, neg, mag, 8'd0};
    s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    if (bad_sum) s = s + 8'($urandom_range(1, 255));
    f[7:0] = s;
    return f;
  endfunction

  // Behavioural model: triggers are at least POLL cycles apart and start one
  // cycle after enable is seen high; the frame present SAMPLE cycles after a
  // trigger starts is judged and published one cycle after that.
  initial begin : model
    longint cyc;
    longint last;
    logic   en_seen;
    logic [39:0] cap;
    cyc = 0; last = -1; en_seen = 1'b0; cap = '0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        cyc = 0; last = -1; en_seen = 1'b0;
        exp_get = 1'b1; exp_hum = '0; exp_temp = '0; exp_valid = 1'b0;
        exp_ns = 1'b0; exp_ferr = 1'b0; exp_cnt = '0;
      end else begin
        cyc++;
        if (en_seen && (last < 0 || cyc - last >= POLL)) last = cyc;
        en_seen = enable;
        exp_ns = 1'b0;
        if (last >= 0 && cyc == last + SAMPLE) cap = dht_data;
        if (last >= 0 && cyc == last + SAMPLE + 1) begin
          if (frame_good(cap)) begin
            exp_hum = cap[39:24];
            exp_temp = frame_temp(cap);
            exp_valid = 1'b1;
            exp_ns = 1'b1;
            exp_ferr = 1'b0;
          end else begin
            exp_ferr = 1'b1;
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
          end
        end
        exp_get = !(last >= 0 && cyc - last < GET);
      end
    end
  end

  // Compare process: every output, every cycle, on the falling edge
  initial begin : compare
    forever begin
      @(negedge clk);
      check("dht_get", 40'(dht_get), 40'(exp_get));
      check("humidity", 40'(humidity), 40'(exp_hum));
      check("temperature", 40'(temperature), 40'(exp_temp));
      check("valid", 40'(valid), 40'(exp_valid));
      check("new_sample", 40'(new_sample), 40'(exp_ns));
      check("frame_err", 40'(frame_err), 40'(exp_ferr));
      check("err_count", 40'(err_count), 40'(exp_cnt));
      if (new_sample === 1'b1) ns_seen++;
    end
  end

  // Wait (bounded) for the trigger to go low; n = falling edges waited
  task automatic wait_trig(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dht_get !== 1'b0 && n < limit);
    if (dht_get !== 1'b0) begin
      n_vec++;
      n_err++;
      $display("FAIL trig_timeout: dht_get=%b after %0d cycles, expected 0", dht_get, n);
    end
  endtask

  task automatic count_lows(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dht_get === 1'b0) lows++;
    end
  endtask

  logic [39:0] dir_data [5] = '{40'h028C010998, 40'h028C010999, 40'h0190806576,
                                40'h03E90000EC, 40'h0000000000};
  logic [15:0] dir_hum  [5] = '{16'd652, 16'd652, 16'd400, 16'd400, 16'd400};
  logic [15:0] dir_temp [5] = '{16'h0109, 16'h0109, 16'hFF9B, 16'hFF9B, 16'hFF9B};
  logic        dir_ferr [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0]  dir_cnt  [5] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
  int          dir_ns   [5] = '{1, 0, 1, 0, 0};

  initial begin : stimulus
    int n;
    int lows;
    logic [39:0] f;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dht_get", 40'(dht_get), 40'd1);
    check("rst_humidity", 40'(humidity), 40'd0);
    check("rst_valid", 40'(valid), 40'd0);
    check("rst_err_count", 40'(err_count), 40'd0);

    // Release with enable high: first trigger two cycles later
    #2 enable = 1'b1;
    reset = 1'b1;
    wait_trig(10, n);
    check("release_to_trig", 40'(n), 40'd2);

    // Directed frames, one per poll
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        wait_trig(250, n);
        check("trig_spacing", 40'(n), 40'd100);
      end
      ns_seen = 0;
      repeat (100) @(negedge clk);
      check("dir_humidity", 40'(humidity), 40'(dir_hum[i]));
      check("dir_temperature", 40'(temperature), 40'(dir_temp[i]));
      check("dir_valid", 40'(valid), 40'd1);
      check("dir_frame_err", 40'(frame_err), 40'(dir_ferr[i]));
      check("dir_err_count", 40'(err_count), 40'(dir_cnt[i]));
      check("dir_new_sample_pulses", 40'(ns_seen), 40'(dir_ns[i]));
      #2 dht_data = (i < 4) ? dir_data[i+1] : 40'h0;
    end

    // Randomized frames, checked by the model
    for (int i = 0; i < 14; i++) begin
      f = make_frame(16'($urandom_range(0, 1010)), 15'($urandom_range(0, 800)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      dht_data = f;
      wait_trig(250, n);
      repeat (100) @(negedge clk);
      #2;
    end

    // Enable dropped during WAIT: sample still completes, no further trigger
    dht_data = 40'h028C010998;
    wait_trig(250, n);
    repeat (10) @(negedge clk);
    #2 enable = 1'b0;
    repeat (90) @(negedge clk);
    check("drop_wait_humidity", 40'(humidity), 40'd652);
    count_lows(400, lows);
    check("drop_wait_no_trig", 40'(lows), 40'd0);
    #2 enable = 1'b1;
    wait_trig(10, n);
    check("reenable_to_trig", 40'(n), 40'd2);

    // Reset in TRIG releases dht_get at once
    #2 reset = 1'b0;
    #1 check("async_get_release", 40'(dht_get), 40'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    wait_trig(10, n);
    check("rst_trig_to_trig", 40'(n), 40'd2);

    // Reset in WAIT clears everything
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    dht_data = make_frame(16'd500, 15'd200, 1'b0, 1'b1);
    #1;
    check("rst_wait_get", 40'(dht_get), 40'd1);
    check("rst_wait_hum", 40'(humidity), 40'd0);
    check("rst_wait_temp", 40'(temperature), 40'd0);
    check("rst_wait_valid", 40'(valid), 40'd0);
    check("rst_wait_ferr", 40'(frame_err), 40'd0);
    check("rst_wait_cnt", 40'(err_count), 40'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    wait_trig(10, n);
    check("rst_wait_to_trig", 40'(n), 40'd2);

    // Bad polls until the error counter saturates
    for (int i = 0; i < 258; i++) begin
      repeat (100) @(negedge clk);
      #2 dht_data = make_frame(16'($urandom_range(0, 1000)), 15'($urandom_range(0, 800)),
                               1'($urandom_range(0, 1)), 1'b1);
      wait_trig(250, n);
    end
    repeat (100) @(negedge clk);
    check("sat_err_count", 40'(err_count), 40'd255);
    check("sat_frame_err", 40'(frame_err), 40'd1);
    check("sat_valid", 40'(valid), 40'd0);

    // Enable dropped during HOLD: no further trigger
    #2 enable = 1'b0;
    count_lows(400, lows);
    check("drop_hold_no_trig", 40'(lows), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
